mac_operand_feeder: RTL and testbench

Upstream operand stage for `mac_unit`. Buffers signed 8-bit operand pairs from a producer through a small FIFO and issues them one at a time to the MAC using its `valid`/`done` protocol. Holds each pair stable until the MAC acknowledges it, and counts pairs so a dot-product boundary is flagged every `VEC_LEN` completions.

---
 rtl/mac_operand_feeder.sv | 127 ++++++++++++
 tb/tb_mac_operand_feeder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - FIFO-buffered operand pair feeder for mac_unit
module mac_operand_feeder #(
  parameter int DEPTH   = 4,
  parameter int VEC_LEN = 8,
  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] in_a,
  input  logic signed [7:0] in_b,
  output logic              mac_valid,
  output logic signed [7:0] mac_a,
  output logic signed [7:0] mac_b,
  input  logic              mac_done,
  output logic              vec_done,
  output logic [IW-1:0]     elem_idx,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              protocol_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic          done_ok, last_elem;

  assign in_ready  = (count < CW'(DEPTH)) && !reset;
  assign push      = in_valid && in_ready;
  assign done_ok   = (state_q == WAIT) && mac_done;
  assign last_elem = (elem_idx == IW'(VEC_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, pop decision and status outputs; done outside WAIT never advances the FSM
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    mac_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (count != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mac_valid = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mac_done) begin
          if (count != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Operand registers load only on a pop, so they hold from ISSUE through the done cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_a <= '0;
      mac_b <= '0;
    end else if (pop) begin
      mac_a <= mem[rd_ptr][15:8];
      mac_b <= mem[rd_ptr][7:0];
    end
  end

  // Element index and vector boundary pulse, advanced by each legitimate completion
  always_ff @(posedge clk) begin
    if (reset) begin
      elem_idx <= '0;
      vec_done <= 1'b0;
    end else begin
      vec_done <= done_ok && last_elem;
      if (done_ok) elem_idx <= last_elem ? '0 : elem_idx + 1'b1;
    end
  end

  // Sticky flag for a done arriving while no pair is awaiting completion
  always_ff @(posedge clk) begin
    if (reset)                         protocol_err <= 1'b0;
    else if (mac_done && state_q != WAIT) protocol_err <= 1'b1;
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - scoreboard bench for mac_operand_feeder
module tb_mac_operand_feeder;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_a = '0, in_b = '0;
  logic              mac_valid;
  logic signed [7:0] mac_a, mac_b;
  logic              mac_done;
  logic              vec_done;
  logic [2:0]        elem_idx;
  logic [2:0]        count;
  logic              busy;
  logic              protocol_err;

  logic              stub_en = 1'b1;
  logic              force_done = 1'b0;
  logic [2:0]        sh;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  logic [15:0]       sb [$];

  mac_operand_feeder #(.DEPTH(4), .VEC_LEN(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .vec_done(vec_done), .elem_idx(elem_idx), .count(count),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MAC stub: done three cycles after each accepted valid
  always @(posedge clk) begin
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], mac_valid & stub_en};
  end
  assign mac_done = (sh[2] & stub_en) | force_done;

  // Monitor: every issued pair must match the oldest accepted pair
  always @(negedge clk) begin
    if (!reset && mac_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got a=%0d b=%0d, expected no issue", mac_a, mac_b);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if ({mac_a, mac_b} !== e) begin
          errors++;
          $display("FAIL issue_data: got a=%0d b=%0d, expected a=%0d b=%0d",
                   mac_a, mac_b, $signed(e[15:8]), $signed(e[7:0]));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  task automatic push_pair(input logic signed [7:0] a, input logic signed [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", in_ready, 1);
    if (in_ready) sb.push_back({a, b});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; force_done = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_ab", {mac_a, mac_b}, 0);
    chk("rst_vec_done", vec_done, 0);
    chk("rst_elem_idx", elem_idx, 0);
    chk("rst_protocol_err", protocol_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int vcyc [$];
    int dcyc [$];
    int vdcyc [$];
    int bad;

    // Single pair: issue at t+2, busy t+2..t+5
    stub_en = 1'b1;
    do_reset();
    in_valid = 1'b1; in_a = 8'sd3; in_b = 8'sd4;
    @(negedge clk);
    chk("single_in_ready", in_ready, 1);
    sb.push_back({8'sd3, 8'sd4});
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("single_t1_valid", mac_valid, 0);
    chk("single_t1_count", count, 1);
    @(negedge clk);
    chk("single_t2_valid", mac_valid, 1);
    chk("single_t2_busy", busy, 1);
    chk("single_t2_count", count, 0);
    @(negedge clk);
    chk("single_t3_valid", mac_valid, 0);
    chk("single_t3_busy", busy, 1);
    @(negedge clk);
    chk("single_t4_busy", busy, 1);
    @(negedge clk);
    chk("single_t5_busy", busy, 1);
    chk("single_t5_done", mac_done, 1);
    chk("single_t5_hold", {mac_a, mac_b}, {8'sd3, 8'sd4});
    @(negedge clk);
    chk("single_t6_busy", busy, 0);
    chk("single_t6_elem_idx", elem_idx, 1);
    chk("single_sb_empty", sb.size(), 0);

    // Back-pressure: MAC never completes until forced
    stub_en = 1'b0;
    do_reset();
    for (int i = 1; i <= 5; i++) push_pair(8'(i), 8'(10 + i));
    in_valid = 1'b1; in_a = 8'sd6; in_b = 8'sd16;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_full_in_ready", in_ready, 0);
      chk("bp_full_count", count, 4);
      @(posedge clk); #1;
    end
    force_done = 1'b1;
    @(posedge clk); #1; force_done = 1'b0;
    @(negedge clk);
    chk("bp_after_pop_count", count, 3);
    chk("bp_after_pop_in_ready", in_ready, 1);
    sb.push_back({8'sd6, 8'sd16});
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_refill_count", count, 4);
    chk("bp_protocol_err", protocol_err, 0);
    @(posedge clk); #1;

    // Stream of 8 pairs: period 4, one vec_done after the 8th done
    stub_en = 1'b1;
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++) push_pair(8'(i), 8'(-i));
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 70; k++) begin
          @(negedge clk);
          if (mac_valid) vcyc.push_back(cyc);
          if (mac_done)  dcyc.push_back(cyc);
          if (vec_done)  vdcyc.push_back(cyc);
        end
      end
    join
    chk("stream_issues", vcyc.size(), 8);
    chk("stream_dones", dcyc.size(), 8);
    bad = 0;
    for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != 4) bad++;
    chk("stream_period_violations", bad, 0);
    chk("stream_vec_done_pulses", vdcyc.size(), 1);
    if (vdcyc.size() == 1 && dcyc.size() == 8)
      chk("stream_vec_done_timing", vdcyc[0] - dcyc[7], 1);
    chk("stream_elem_idx_end", elem_idx, 0);
    chk("stream_sb_empty", sb.size(), 0);

    // Ordering extremes with a push and pop in the same cycle at count=2
    stub_en = 1'b0;
    do_reset();
    push_pair(-8'sd128, 8'sd127);
    push_pair(8'sd127, -8'sd128);
    push_pair(-8'sd1, -8'sd1);
    in_valid = 1'b1; in_a = 8'sd5; in_b = -8'sd7; force_done = 1'b1;
    @(negedge clk);
    chk("order_pre_count", count, 2);
    chk("order_pre_in_ready", in_ready, 1);
    sb.push_back({8'sd5, -8'sd7});
    @(posedge clk); #1;
    in_valid = 1'b0; force_done = 1'b0; stub_en = 1'b1;
    @(negedge clk);
    chk("order_simul_count", count, 2);
    chk("order_simul_valid", mac_valid, 1);
    repeat (20) @(negedge clk);
    chk("order_drain_count", count, 0);
    chk("order_drain_busy", busy, 0);
    chk("order_sb_empty", sb.size(), 0);
    chk("order_protocol_err", protocol_err, 0);
    @(posedge clk); #1;

    // Spurious done in IDLE
    do_reset();
    force_done = 1'b1;
    @(posedge clk); #1; force_done = 1'b0;
    @(negedge clk);
    chk("spur_protocol_err", protocol_err, 1);
    chk("spur_busy", busy, 0);
    chk("spur_count", count, 0);
    chk("spur_elem_idx", elem_idx, 0);
    repeat (3) @(negedge clk);
    chk("spur_sticky", protocol_err, 1);
    @(posedge clk); #1;

    // Reset mid-WAIT with three queued entries
    stub_en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push_pair(8'(20 + i), 8'(30 + i));
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_count", count, 3);
    chk("midrst_pre_busy", busy, 1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; sb.delete();
    @(negedge clk);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_elem_idx", elem_idx, 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (mac_valid || !in_ready) bad++;
      @(negedge clk);
    end
    chk("midrst_quiet_cycles", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
